// File: rtl/system_arb_pkg.sv
// Shared types and constants for the AXI4-Lite write-channel arbiter.
package system_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StResp,
        StTimeout,
        StDrain
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One-hot encoding of a 2-way owner index.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/system_rr_arb2.sv
// Two-way round-robin picker. Purely combinational; the caller registers the result.
module system_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // Sole requester wins; on a tie the requester that did not win last time goes first.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/system_axil_wr_arbiter.sv
// 2:1 AXI4-Lite write-channel arbiter with round-robin grant, one outstanding write,
// and a response watchdog that answers SLVERR when the slave never responds.
module system_axil_wr_arbiter
    import system_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [2*ADDR_W-1:0]     s_awaddr,
    input  logic [1:0]              s_awvalid,
    output logic [1:0]              s_awready,
    input  logic [2*DATA_W-1:0]     s_wdata,
    input  logic [2*DATA_W/8-1:0]   s_wstrb,
    input  logic [1:0]              s_wvalid,
    output logic [1:0]              s_wready,
    output logic [3:0]              s_bresp,
    output logic [1:0]              s_bvalid,
    input  logic [1:0]              s_bready,
    output logic [ADDR_W-1:0]       m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_W-1:0]       m_wdata,
    output logic [DATA_W/8-1:0]     m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [1:0]              grant,
    output logic                    err_timeout,
    input  logic                    err_clr
);

    localparam int unsigned StrbW = DATA_W / 8;
    localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e      state_q, state_d;
    logic            owner_q, owner_d;
    logic            rr_last_q, rr_last_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
    logic            err_q, err_d;
    logic [1:0]      pick_gnt;
    logic            timeout_hit;

    system_rr_arb2 u_rr_arb2 (
        .req_i  (s_awvalid),
        .last_i (rr_last_q),
        .gnt_o  (pick_gnt)
    );

    // State and bookkeeping registers; reset abandons any transaction in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wd_cnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wd_cnt_q  <= wd_cnt_d;
            err_q     <= err_d;
        end
    end

    // A real response in the expiry cycle takes precedence over the watchdog.
    assign timeout_hit = (TIMEOUT != 0) && !m_bvalid &&
                         (wd_cnt_q >= CntW'(TIMEOUT - 1));

    // Next-state: arbitration, per-channel completion tracking and the watchdog.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wd_cnt_d  = wd_cnt_q;
        err_d     = err_q & ~err_clr;
        unique case (state_q)
            StIdle: begin
                if (|s_awvalid) begin
                    state_d   = StAddr;
                    owner_d   = pick_gnt[1];
                    rr_last_d = pick_gnt[1];
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            StAddr: begin
                aw_done_d = aw_done_q | (m_awvalid & m_awready);
                w_done_d  = w_done_q | (m_wvalid & m_wready);
                if (aw_done_d && w_done_d) begin
                    state_d  = StResp;
                    wd_cnt_d = '0;
                end
            end
            StResp: begin
                if (m_bvalid && m_bready) begin
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    state_d = StTimeout;
                    err_d   = 1'b1;
                end else if (wd_cnt_q != CntW'(TIMEOUT)) begin
                    wd_cnt_d = wd_cnt_q + CntW'(1);
                end
            end
            StTimeout: begin
                if (s_bready[owner_q]) state_d = StDrain;
            end
            StDrain: begin
                if (m_bvalid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: route the owner's channels to the slave; everything else stays quiet.
    always_comb begin
        m_awaddr  = owner_q ? s_awaddr[ADDR_W +: ADDR_W] : s_awaddr[0 +: ADDR_W];
        m_wdata   = owner_q ? s_wdata[DATA_W +: DATA_W] : s_wdata[0 +: DATA_W];
        m_wstrb   = owner_q ? s_wstrb[StrbW +: StrbW] : s_wstrb[0 +: StrbW];
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        s_awready = 2'b00;
        s_wready  = 2'b00;
        s_bvalid  = 2'b00;
        s_bresp   = 4'b0000;
        grant     = (state_q == StIdle) ? 2'b00 : onehot2(owner_q);
        err_timeout = err_q;
        unique case (state_q)
            StAddr: begin
                m_awvalid          = s_awvalid[owner_q] & ~aw_done_q;
                m_wvalid           = s_wvalid[owner_q] & ~w_done_q;
                s_awready[owner_q] = m_awready & ~aw_done_q;
                s_wready[owner_q]  = m_wready & ~w_done_q;
            end
            StResp: begin
                s_bvalid[owner_q]              = m_bvalid;
                s_bresp[{owner_q, 1'b0} +: 2] = m_bresp;
                m_bready                       = s_bready[owner_q];
            end
            StTimeout: begin
                s_bvalid[owner_q]              = 1'b1;
                s_bresp[{owner_q, 1'b0} +: 2] = RESP_SLVERR;
            end
            StDrain: m_bready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_system_axil_wr_arbiter.sv
// Bench for system_axil_wr_arbiter: vector table, hand-written corner sequences and a
// randomized run checked against a round-robin reference model.
module tb_system_axil_wr_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 16;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [2*AW-1:0] s_awaddr;
    logic [1:0]      s_awvalid, s_awready;
    logic [2*DW-1:0] s_wdata;
    logic [2*SW-1:0] s_wstrb;
    logic [1:0]      s_wvalid, s_wready;
    logic [3:0]      s_bresp;
    logic [1:0]      s_bvalid, s_bready;
    logic [AW-1:0]   m_awaddr;
    logic            m_awvalid, m_awready;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_wstrb;
    logic            m_wvalid, m_wready;
    logic [1:0]      m_bresp;
    logic            m_bvalid, m_bready;
    logic [1:0]      grant;
    logic            err_timeout, err_clr;

    int checks = 0;
    int failures = 0;

    // Reference model state: pending requests, their payloads, and the last winner.
    bit   [1:0]  pend;
    logic [31:0] addr_of [2];
    logic [31:0] data_of [2];
    logic [3:0]  strb_of [2];
    int          tb_last;

    typedef struct {
        bit          rst;
        bit [1:0]    req;
        logic [31:0] a0, a1, d0, d1;
        int          aw_dly, w_dly, b_dly;
        logic [1:0]  bresp;
        int          exp_own;
    } vec_t;

    always #5 aclk = ~aclk;

    system_axil_wr_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_awaddr    (s_awaddr),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .s_bresp     (s_bresp),
        .s_bvalid    (s_bvalid),
        .s_bready    (s_bready),
        .m_awaddr    (m_awaddr),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .grant       (grant),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arbitration rule: sole requester wins, a tie goes to the one that did not win last.
    function automatic int pick(input bit [1:0] p, input int last);
        if (p == 2'b11) return (last == 0) ? 1 : 0;
        return p[1] ? 1 : 0;
    endfunction

    task automatic do_reset();
        aresetn   = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 2'b00;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 2'b00;
        s_bready  = 2'b11;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bresp   = 2'b00;
        m_bvalid  = 1'b0;
        err_clr   = 1'b0;
        pend      = 2'b00;
        tb_last   = 1;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        #1;
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_err", 64'(err_timeout), 64'(0));
        check("rst_s_ready", 64'({s_awready, s_wready, s_bvalid}), 64'(0));
        check("rst_m_side", 64'({m_awvalid, m_wvalid, m_bready}), 64'(0));
    endtask

    task automatic present(input int i, input logic [31:0] a, input logic [31:0] d);
        addr_of[i]          = a;
        data_of[i]          = d;
        strb_of[i]          = d[7:4] | 4'b0001;
        s_awaddr[i*AW +: AW] = a;
        s_wdata[i*DW +: DW]  = d;
        s_wstrb[i*SW +: SW]  = strb_of[i];
        s_awvalid[i]        = 1'b1;
        s_wvalid[i]         = 1'b1;
        pend[i]             = 1'b1;
    endtask

    // Acts as the slave for one transaction starting in an IDLE cycle and checks routing.
    task automatic serve(input int own, input int aw_dly, input int w_dly, input int b_dly,
                         input logic [1:0] bresp, input bit hold);
        bit         aw_hs = 0;
        bit         w_hs = 0;
        bit         b_hs = 0;
        int         w_cnt = 0;
        int         bcnt = 0;
        int         cyc = 0;
        int         oth = 1 - own;
        logic [1:0] oh = (own == 1) ? 2'b10 : 2'b01;
        while (!b_hs && cyc < 200) begin
            m_awready = (cyc >= aw_dly);
            m_wready  = (cyc >= w_dly);
            if (aw_hs && w_hs) begin
                m_bvalid = (bcnt >= b_dly);
                m_bresp  = bresp;
                bcnt++;
            end
            #1;
            if (cyc == 0) check("idle_grant", 64'(grant), 64'(0));
            if (cyc == 0) check("idle_awvalid", 64'(m_awvalid), 64'(0));
            if (cyc == 1) check("addr_latency", 64'(m_awvalid), 64'(1));
            if (cyc >= 1) check("grant_owner", 64'(grant), 64'(oh));
            check("nonowner_quiet", 64'({s_awready[oth], s_wready[oth], s_bvalid[oth]}), 64'(0));
            check("aw_ready_path", 64'(s_awready[own] & s_awvalid[own]),
                  64'(m_awvalid & m_awready));
            check("w_ready_path", 64'(s_wready[own] & s_wvalid[own]), 64'(m_wvalid & m_wready));
            if (aw_hs) check("aw_masked", 64'(m_awvalid), 64'(0));
            if (w_hs) check("w_masked", 64'(m_wvalid), 64'(0));
            if (!(aw_hs && w_hs)) check("no_early_b", 64'({m_bready, s_bvalid[own]}), 64'(0));
            if (m_awvalid && m_awready) begin
                check("m_awaddr", 64'(m_awaddr), 64'(addr_of[own]));
                aw_hs = 1;
            end
            if (m_wvalid && m_wready) begin
                check("m_wdata", 64'(m_wdata), 64'(data_of[own]));
                check("m_wstrb", 64'(m_wstrb), 64'(strb_of[own]));
                w_cnt++;
                w_hs = 1;
            end
            if (m_bvalid) begin
                check("s_bvalid", 64'(s_bvalid[own]), 64'(1));
                check("s_bresp", 64'(s_bresp[own*2 +: 2]), 64'(bresp));
            end
            if (m_bvalid && m_bready) b_hs = 1;
            @(posedge aclk);
            #1;
            cyc++;
            if (aw_hs && !hold) s_awvalid[own] = 1'b0;
            if (w_hs && !hold) s_wvalid[own] = 1'b0;
        end
        m_bvalid       = 1'b0;
        m_awready      = 1'b0;
        m_wready       = 1'b0;
        s_awvalid[own] = 1'b0;
        s_wvalid[own]  = 1'b0;
        pend[own]      = 1'b0;
        tb_last        = own;
        check("b_done", 64'(b_hs), 64'(1));
        check("w_single", 64'(w_cnt), 64'(1));
        #1 check("grant_after_b", 64'(grant), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [7];
        tbl[0] = '{1, 2'b01, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 0, 2'b00, 0};
        tbl[1] = '{1, 2'b11, 32'h200, 32'h300, 32'h2222_0000, 32'h3333_0000, 0, 0, 0, 2'b00, 0};
        tbl[2] = '{0, 2'b01, 32'h210, 32'h0, 32'h2222_0010, 32'h0, 1, 0, 0, 2'b00, 1};
        tbl[3] = '{0, 2'b10, 32'h0, 32'h310, 32'h0, 32'h3333_0010, 0, 1, 1, 2'b00, 0};
        tbl[4] = '{0, 2'b01, 32'h220, 32'h0, 32'h2222_0020, 32'h0, 0, 0, 0, 2'b00, 1};
        tbl[5] = '{0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 2'b01, 0};
        tbl[6] = '{0, 2'b10, 32'h0, 32'h330, 32'h0, 32'h3333_0030, 2, 3, 2, 2'b11, 1};

        do_reset();
        for (int r = 0; r < 7; r++) begin
            if (tbl[r].rst) do_reset();
            if (tbl[r].req[0] && !pend[0]) present(0, tbl[r].a0, tbl[r].d0);
            if (tbl[r].req[1] && !pend[1]) present(1, tbl[r].a1, tbl[r].d1);
            serve(tbl[r].exp_own, tbl[r].aw_dly, tbl[r].w_dly, tbl[r].b_dly, tbl[r].bresp, 1'b0);
        end

        // W presented well before AW, slow AW ready; valids held to exercise masking.
        present(1, 32'h500, 32'hCAFE_0001);
        s_awvalid[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check("w_first_idle", 64'(grant), 64'(0));
            @(posedge aclk);
            #1;
        end
        s_awvalid[1] = 1'b1;
        serve(1, 6, 0, 1, 2'b00, 1'b1);

        // Watchdog: slave never answers, SLVERR after TO RESP cycles, then drain.
        s_bready  = 2'b00;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        present(0, 32'h400, 32'h4444_0000);
        @(posedge aclk);
        #1 check("to_grant", 64'(grant), 64'(2'b01));
        @(posedge aclk);
        #1;
        s_awvalid[0] = 1'b0;
        s_wvalid[0]  = 1'b0;
        m_awready    = 1'b0;
        m_wready     = 1'b0;
        for (int k = 0; k < int'(TO); k++) begin
            #1 check("to_wait", 64'(s_bvalid), 64'(0));
            @(posedge aclk);
            #1;
        end
        #1 check("to_bvalid", 64'(s_bvalid), 64'(2'b01));
        check("to_bresp", 64'(s_bresp[1:0]), 64'(2'b10));
        check("to_err", 64'(err_timeout), 64'(1));
        check("to_no_mbready", 64'(m_bready), 64'(0));
        @(posedge aclk);
        #1 check("to_hold", 64'({s_bvalid, s_bresp[1:0]}), 64'(4'b0110));
        s_bready = 2'b11;
        @(posedge aclk);
        #1;
        present(1, 32'h600, 32'h6666_0000);
        #1 check("drain_mbready", 64'(m_bready), 64'(1));
        check("drain_sbvalid", 64'(s_bvalid), 64'(0));
        @(posedge aclk);
        #1 check("drain_no_grant", 64'(grant), 64'(2'b01));
        m_bvalid = 1'b1;
        m_bresp  = 2'b00;
        #1 check("drain_discard", 64'(s_bvalid), 64'(0));
        @(posedge aclk);
        #1;
        m_bvalid = 1'b0;
        err_clr  = 1'b1;
        #1 check("idle_after_drain", 64'(grant), 64'(0));
        check("err_sticky", 64'(err_timeout), 64'(1));
        @(posedge aclk);
        #1;
        err_clr = 1'b0;
        check("err_cleared", 64'(err_timeout), 64'(0));
        check("grant_m1", 64'(grant), 64'(2'b10));
        m_awready = 1'b1;
        m_wready  = 1'b1;
        @(posedge aclk);
        #1;
        s_awvalid[1] = 1'b0;
        s_wvalid[1]  = 1'b0;
        m_awready    = 1'b0;
        m_wready     = 1'b0;
        pend         = 2'b00;
        // Real response arrives in the very cycle the watchdog would expire.
        repeat (TO - 1) @(posedge aclk);
        #1;
        m_bvalid = 1'b1;
        m_bresp  = 2'b01;
        #1 check("late_b_fwd", 64'({s_bvalid, s_bresp[3:2]}), 64'(4'b1001));
        @(posedge aclk);
        #1;
        m_bvalid = 1'b0;
        tb_last  = 1;
        #1 check("late_b_grant", 64'(grant), 64'(0));
        check("late_b_no_err", 64'(err_timeout), 64'(0));

        // Reset in RESP with m0 owning: everything goes quiet at once.
        m_awready = 1'b1;
        m_wready  = 1'b1;
        present(0, 32'h700, 32'h7777_0000);
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1;
        s_awvalid[0] = 1'b0;
        s_wvalid[0]  = 1'b0;
        m_bvalid     = 1'b1;
        #1 check("pre_rst_bvalid", 64'(s_bvalid), 64'(2'b01));
        #1 aresetn = 1'b0;
        #1;
        check("mid_rst_grant", 64'(grant), 64'(0));
        check("mid_rst_s", 64'({s_awready, s_wready, s_bvalid}), 64'(0));
        check("mid_rst_m", 64'({m_awvalid, m_wvalid, m_bready}), 64'(0));
        do_reset();
        present(1, 32'h800, 32'h8888_0000);
        serve(1, 0, 0, 0, 2'b00, 1'b0);

        // Randomized traffic against the round-robin model.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) present(i, $urandom, $urandom);
            end
            if (pend == 2'b00) present(int'($urandom_range(0, 1)), $urandom, $urandom);
            serve(pick(pend, tb_last), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
        end
        if (pend != 2'b00) serve(pick(pend, tb_last), 0, 0, 0, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
